// File: rtl/q_learn_pkg.sv
// Shared definitions for the Q-learning datapath (max-Q comparator and the
// Q update stage).
//   DW   : Q-value / reward width. Q8.8. Q values are unsigned, rewards are
//          two's complement.
//   FRAC : fractional bits of Q, reward and coefficients.
//   CW   : alpha / gamma width. Unsigned Q0.8.
//   AW   : Q-table address (state-action index) width.
//   sat_u: clamps a signed DW+3 bit value into the unsigned DW range.
package q_learn_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int CW   = 8;
    localparam int AW   = 8;

    // Sign bit set: negative, clamp to 0. Any bit above DW-1 set: too big,
    // clamp to all ones. Otherwise the low DW bits are the value.
    function automatic logic [DW-1:0] sat_u(input logic signed [DW+2:0] v);
        if (v[DW+2])
            return '0;
        else if (|v[DW+1:DW])
            return '1;
        else
            return v[DW-1:0];
    endfunction

endpackage

// File: rtl/q_fwd_unit.sv
// Read-after-write forwarding for the Q update stage.
// The Q-table write commits at the end of the out_valid cycle, so a q_cur
// read 1 or 2 cycles after a same-address transaction is stale. This unit
// replaces it with the newest in-flight result.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   out_valid_i   : output register valid (newest result)
//   out_addr_i    : output register address
//   q_new_i       : output register value
//   r1_addr_i     : address of the transaction in stage 2
//   r1_q_i        : q_cur sampled with that transaction
//   q_eff_o       : value stage 2 should use as Q(s,a)
module q_fwd_unit
    import q_learn_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          out_valid_i,
    input  logic [AW-1:0] out_addr_i,
    input  logic [DW-1:0] q_new_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [DW-1:0] r1_q_i,
    output logic [DW-1:0] q_eff_o
);

    // Hold register: a copy of the previous cycle's output registers. It
    // ages every cycle, so an idle output cycle invalidates it.
    logic          hold_vld_q;
    logic [AW-1:0] hold_addr_q;
    logic [DW-1:0] hold_q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_q_q    <= '0;
        end else begin
            hold_vld_q  <= out_valid_i;
            hold_addr_q <= out_addr_i;
            hold_q_q    <= q_new_i;
        end
    end

    logic hit_out;
    logic hit_hold;

    assign hit_out  = out_valid_i && (out_addr_i == r1_addr_i);
    assign hit_hold = hold_vld_q && (hold_addr_q == r1_addr_i);

    // Output registers are newer than the hold register, so they win.
    always_comb begin
        q_eff_o = r1_q_i;
        if (hit_out)
            q_eff_o = q_new_i;
        else if (hit_hold)
            q_eff_o = hold_q_q;
    end

endmodule

// File: rtl/q_update.sv
// Q-learning update stage, downstream of the max-Q comparator.
//   Q_new = Q + alpha*(r + gamma*maxQ - Q), Q8.8 fixed point, clamped to the
//   unsigned DW range. Two-stage pipeline, one transaction per cycle, no
//   backpressure; in_valid at t gives out_valid at t+2.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (drops in-flight work)
//   in_valid   : transaction present
//   in_addr    : Q-table address being updated
//   q_cur      : current Q(s,a), unsigned
//   max_q      : max_a' Q(s',a'), unsigned
//   reward     : signed reward
//   alpha      : learning rate, Q0.8
//   gamma      : discount factor, Q0.8
//   out_valid  : Q-table write enable
//   out_addr   : write address
//   q_new      : updated Q value
//   sat        : q_new was clamped
module q_update
    import q_learn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] q_cur,
    input  logic [DW-1:0] max_q,
    input  logic [DW-1:0] reward,
    input  logic [CW-1:0] alpha,
    input  logic [CW-1:0] gamma,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] q_new,
    output logic          sat
);

    localparam int GW  = DW + CW;     // gamma*max_q product
    localparam int TDW = DW + 2;      // temporal difference
    localparam int PW  = DW + CW + 2; // alpha*td product
    localparam int SW  = DW + 3;      // q_eff + delta

    // ---------------- S1: discounted max-Q ----------------
    logic [GW-1:0] gm_prod;
    logic [DW-1:0] t_d;

    assign gm_prod = {{DW{1'b0}}, gamma} * {{CW{1'b0}}, max_q};
    assign t_d     = DW'(gm_prod >> FRAC);

    logic          r1_vld_q;
    logic [AW-1:0] r1_addr_q;
    logic [DW-1:0] r1_t_q;
    logic [DW-1:0] r1_rew_q;
    logic [DW-1:0] r1_q_q;
    logic [CW-1:0] r1_alpha_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld_q   <= 1'b0;
            r1_addr_q  <= '0;
            r1_t_q     <= '0;
            r1_rew_q   <= '0;
            r1_q_q     <= '0;
            r1_alpha_q <= '0;
        end else begin
            r1_vld_q <= in_valid;
            if (in_valid) begin
                r1_addr_q  <= in_addr;
                r1_t_q     <= t_d;
                r1_rew_q   <= reward;
                r1_q_q     <= q_cur;
                r1_alpha_q <= alpha;
            end
        end
    end

    // ---------------- S2: TD error, scale, clamp ----------------
    logic          out_vld_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] q_new_q;
    logic          sat_q;
    logic [DW-1:0] q_eff;

    q_fwd_unit u_fwd (
        .clk_i       (clk),
        .rst_i       (rst),
        .out_valid_i (out_vld_q),
        .out_addr_i  (out_addr_q),
        .q_new_i     (q_new_q),
        .r1_addr_i   (r1_addr_q),
        .r1_q_i      (r1_q_q),
        .q_eff_o     (q_eff)
    );

    logic signed [TDW-1:0] td;
    logic signed [PW-1:0]  prod;
    logic signed [TDW-1:0] delta;
    logic signed [SW-1:0]  sum;
    logic [DW-1:0]         q_new_d;
    logic                  sat_d;

    // td range is about +/-98k, fits DW+2 signed; alpha*td fits DW+CW+2.
    assign td    = $signed({{2{r1_rew_q[DW-1]}}, r1_rew_q})
                 + $signed({2'b00, r1_t_q})
                 - $signed({2'b00, q_eff});
    assign prod  = $signed({{(PW-CW){1'b0}}, r1_alpha_q})
                 * $signed({{(PW-TDW){td[TDW-1]}}, td});
    // Arithmetic shift floors toward minus infinity.
    assign delta = TDW'(prod >>> FRAC);
    assign sum   = $signed({3'b000, q_eff}) + $signed({delta[TDW-1], delta});

    assign q_new_d = sat_u(sum);
    assign sat_d   = sum[SW-1] | (|sum[SW-2:DW]);

    // q_new, out_addr and sat hold their last values on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            q_new_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            out_vld_q <= r1_vld_q;
            if (r1_vld_q) begin
                out_addr_q <= r1_addr_q;
                q_new_q    <= q_new_d;
                sat_q      <= sat_d;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_addr  = out_addr_q;
    assign q_new     = q_new_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_q_update.sv
module tb_q_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_addr;
    logic [15:0] q_cur, max_q, reward;
    logic [7:0]  alpha, gamma;
    logic        out_valid;
    logic [7:0]  out_addr;
    logic [15:0] q_new;
    logic        sat;

    q_update dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
        .q_cur(q_cur), .max_q(max_q), .reward(reward), .alpha(alpha),
        .gamma(gamma), .out_valid(out_valid), .out_addr(out_addr),
        .q_new(q_new), .sat(sat)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;

    // Scoreboard: expected writes stamped with the cycle they must appear.
    typedef struct {
        int          due;
        logic [7:0]  a;
        logic [15:0] q;
        bit          s;
    } exp_t;
    exp_t exp_q[$];

    // Last two accepted transactions (1 and 2 cycles ago) and their results;
    // these are the writes a fresh q_cur read cannot yet see.
    bit          h1_v = 0, h2_v = 0;
    logic [7:0]  h1_a, h2_a;
    int          h1_q, h2_q;

    // Reference arithmetic on plain integers.
    task automatic model(input int qe, input int mq, input int r, input int a,
                         input int g, output int res, output bit s);
        int t, td, p, d, sm;
        t  = (g * mq) / 256;
        td = r + t - qe;
        p  = a * td;
        d  = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        sm = qe + d;
        if (sm < 0) begin res = 0; s = 1; end
        else if (sm > 65535) begin res = 65535; s = 1; end
        else begin res = sm; s = 0; end
    endtask

    // Apply one cycle of input, record the expected write, advance one clock
    // and return #1 after the edge.
    task automatic drive(input bit v, input logic [7:0] ad, input logic [15:0] qc,
                         input logic [15:0] mq, input logic [15:0] rw,
                         input logic [7:0] al, input logic [7:0] gm);
        int   qe, res;
        bit   s;
        exp_t e;
        in_valid = v; in_addr = ad; q_cur = qc; max_q = mq;
        reward = rw; alpha = al; gamma = gm;
        res = 0;
        if (v) begin
            qe = int'(qc);
            if (h2_v && h2_a == ad) qe = h2_q;
            if (h1_v && h1_a == ad) qe = h1_q;
            model(qe, int'(mq), int'($signed(rw)), int'(al), int'(gm), res, s);
            e.due = cyc + 2; e.a = ad; e.q = 16'(res); e.s = s;
            exp_q.push_back(e);
        end
        h2_v = h1_v; h2_a = h1_a; h2_q = h1_q;
        h1_v = v;    h1_a = ad;   h1_q = res;
        @(posedge clk); #1; cyc++;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; cyc++; end
        rst = 1'b0;
        exp_q.delete(); h1_v = 0; h2_v = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vec++; if (out_addr !== 8'h00) begin miss++; $display("FAIL reset_addr got %h want 00", out_addr); end
        vec++; if (q_new !== 16'h0000) begin miss++; $display("FAIL reset_qnew got %h want 0000", q_new); end
        vec++; if (sat !== 1'b0) begin miss++; $display("FAIL reset_sat got %b want 0", sat); end
    endtask

    task automatic test_single();
        drive(1'b1, 8'd3, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL single_early got %b want 0", out_valid); end
        idle();
        vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL single_valid got %b want 1", out_valid); end
        vec++; if (out_addr !== 8'd3) begin miss++; $display("FAIL single_addr got %h want 03", out_addr); end
        vec++; if (q_new !== 16'h0180 || sat !== 1'b0) begin miss++; $display("FAIL single_qnew got %h/%b want 0180/0", q_new, sat); end
        idle();
        vec++; if (out_valid !== 1'b0 || q_new !== 16'h0180 || out_addr !== 8'd3) begin
            miss++; $display("FAIL single_hold got v%b %h@%h want v0 0180@03", out_valid, q_new, out_addr); end
    endtask

    task automatic test_arith();
        drive(1'b1, 8'd7, 16'h0400, 16'h0000, 16'hFF00, 8'h40, 8'h80); idle();
        vec++; if (q_new !== 16'h02C0 || sat !== 1'b0) begin miss++; $display("FAIL neg_td got %h/%b want 02C0/0", q_new, sat); end
        drive(1'b1, 8'd8, 16'h0010, 16'h1234, 16'h8000, 8'hFF, 8'h00); idle();
        vec++; if (q_new !== 16'h0000 || sat !== 1'b1) begin miss++; $display("FAIL low_clamp got %h/%b want 0000/1", q_new, sat); end
        drive(1'b1, 8'd9, 16'hFF00, 16'hFFFF, 16'h7FFF, 8'hFF, 8'hFF); idle();
        vec++; if (q_new !== 16'hFFFF || sat !== 1'b1) begin miss++; $display("FAIL high_clamp got %h/%b want FFFF/1", q_new, sat); end
        repeat (2) idle();
    endtask

    task automatic test_hazard();
        logic [15:0] want;
        for (int gap = 1; gap <= 3; gap++) begin
            drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
            repeat (gap - 1) idle();
            drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
            idle();
            want = (gap < 3) ? 16'h01C0 : 16'h0180;
            vec++; if (out_valid !== 1'b1 || q_new !== want) begin
                miss++; $display("FAIL hazard_gap%0d got v%b %h want v1 %h", gap, out_valid, q_new, want); end
            repeat (3) idle();
        end
        // Different address directly behind: no forwarding.
        drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        drive(1'b1, 8'd6, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        idle();
        vec++; if (q_new !== 16'h0180 || out_addr !== 8'd6) begin
            miss++; $display("FAIL hazard_diffaddr got %h@%h want 0180@06", q_new, out_addr); end
        repeat (3) idle();
        // Three in a row: third must use the second's result, not the first.
        repeat (3) drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        idle();
        vec++; if (q_new !== 16'h01E0) begin miss++; $display("FAIL hazard_prio got %h want 01E0", q_new); end
        repeat (3) idle();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        // rst together with a third transaction: everything is dropped.
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; cyc++;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); h1_v = 0; h2_v = 0;
        vec++; if (out_valid !== 1'b0 || q_new !== 16'h0000) begin
            miss++; $display("FAIL midrst_c1 got v%b %h want v0 0000", out_valid, q_new); end
        drive(1'b1, 8'd5, 16'h0100, 16'h0200, 16'h0100, 8'h80, 8'h80);
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL midrst_c2 got %b want 0", out_valid); end
        idle();
        vec++; if (out_valid !== 1'b1 || q_new !== 16'h0180) begin
            miss++; $display("FAIL midrst_nofwd got v%b %h want v1 0180", out_valid, q_new); end
        repeat (3) idle();
    endtask

    task automatic test_random();
        exp_t        e;
        logic [15:0] last_q = 16'h0;
        logic [7:0]  last_a = 8'h0;
        bit          v;
        do_reset();
        for (int i = 0; i < 2002; i++) begin
            v = (i < 2000) && ($urandom_range(0, 3) != 0);
            drive(v, 8'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                  16'($urandom), 8'($urandom), 8'($urandom));
            vec++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_addr !== e.a || q_new !== e.q || sat !== e.s) begin
                    miss++;
                    $display("FAIL rand_write cyc%0d got v%b %h@%h s%b want v1 %h@%h s%b",
                             cyc, out_valid, q_new, out_addr, sat, e.q, e.a, e.s);
                end
                last_q = e.q; last_a = e.a;
            end else if (out_valid !== 1'b0 || q_new !== last_q || out_addr !== last_a) begin
                miss++;
                $display("FAIL rand_idle cyc%0d got v%b %h@%h want v0 %h@%h",
                         cyc, out_valid, q_new, out_addr, last_q, last_a);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; q_cur = '0; max_q = '0;
        reward = '0; alpha = '0; gamma = '0;
        test_reset();
        test_single();
        test_arith();
        test_hazard();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
